// File: rtl/fpu_result_collector.sv
// Registered FPU result collector: issues to one unit slot, waits for its ready
// with a watchdog, and holds the captured result under a valid/ready handshake.
module fpu_result_collector #(
  parameter int                   DATA_W    = 32,
  parameter int                   FLAG_W    = 4,
  parameter int                   NUM_UNITS = 16,
  parameter int                   SEL_W     = 4,
  parameter logic [NUM_UNITS-1:0] UNIT_MASK = 16'h7777,
  parameter int                   TIMEOUT   = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        issue_valid,
  output logic                        issue_ready,
  input  logic [SEL_W-1:0]            issue_sel,
  input  logic [NUM_UNITS*DATA_W-1:0] unit_data,
  input  logic [NUM_UNITS*FLAG_W-1:0] unit_flags,
  input  logic [NUM_UNITS-1:0]        unit_ready,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [DATA_W-1:0]           res_data,
  output logic [FLAG_W-1:0]           res_flags,
  output logic [SEL_W-1:0]            res_unit,
  output logic                        res_err,
  output logic                        busy
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               issue_ready_q;
  logic               busy_q;
  logic               res_valid_q;
  logic               res_err_q;
  logic [DATA_W-1:0]  res_data_q;
  logic [FLAG_W-1:0]  res_flags_q;
  logic [SEL_W-1:0]   res_unit_q;

  // Slot exists and is implemented; out-of-range selects never match any bit.
  function automatic logic slot_ok(input logic [SEL_W-1:0] s);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      ok = ok | ((s == SEL_W'(i)) & UNIT_MASK[i]);
    end
    return ok;
  endfunction

  logic [DATA_W-1:0] sel_data_s;
  logic [FLAG_W-1:0] sel_flags_s;
  logic              sel_ready_s;

  assign sel_data_s  = unit_data[int'(sel_q)*DATA_W +: DATA_W];
  assign sel_flags_s = unit_flags[int'(sel_q)*FLAG_W +: FLAG_W];
  assign sel_ready_s = unit_ready[sel_q];

  // Collector FSM with all outputs held in registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sel_q         <= '0;
      cnt_q         <= '0;
      issue_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_err_q     <= 1'b0;
      res_data_q    <= '0;
      res_flags_q   <= '0;
      res_unit_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (issue_valid) begin
            sel_q         <= issue_sel;
            issue_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            if (slot_ok(issue_sel)) begin
              state_q <= ST_WAIT;
              cnt_q   <= '0;
            end else begin
              state_q     <= ST_HOLD;
              res_valid_q <= 1'b1;
              res_err_q   <= 1'b1;
              res_data_q  <= '0;
              res_flags_q <= '0;
              res_unit_q  <= issue_sel;
            end
          end
        end
        ST_WAIT: begin
          // Ready takes priority over the watchdog in the same cycle
          if (sel_ready_s) begin
            state_q     <= ST_HOLD;
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b0;
            res_data_q  <= sel_data_s;
            res_flags_q <= sel_flags_s;
            res_unit_q  <= sel_q;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= ST_HOLD;
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b1;
            res_data_q  <= '0;
            res_flags_q <= '0;
            res_unit_q  <= sel_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            state_q       <= ST_IDLE;
            res_valid_q   <= 1'b0;
            issue_ready_q <= 1'b1;
            busy_q        <= 1'b0;
          end
        end
        default: begin
          state_q       <= ST_IDLE;
          res_valid_q   <= 1'b0;
          issue_ready_q <= 1'b1;
          busy_q        <= 1'b0;
        end
      endcase
    end
  end

  assign issue_ready = issue_ready_q;
  assign busy        = busy_q;
  assign res_valid   = res_valid_q;
  assign res_err     = res_err_q;
  assign res_data    = res_data_q;
  assign res_flags   = res_flags_q;
  assign res_unit    = res_unit_q;

endmodule

// File: tb/tb_fpu_result_collector.sv
// Scoreboard bench for fpu_result_collector (watchdog shortened to 4 cycles).
module tb_fpu_result_collector;

  localparam int DW = 32;
  localparam int FW = 4;
  localparam int NU = 16;
  localparam int SW = 4;
  localparam int TO = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [FW-1:0] f;
    logic [SW-1:0] u;
    logic          e;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             issue_valid = 1'b0;
  logic             issue_ready;
  logic [SW-1:0]    issue_sel = '0;
  logic [NU*DW-1:0] unit_data = '0;
  logic [NU*FW-1:0] unit_flags = '0;
  logic [NU-1:0]    unit_ready = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [DW-1:0]    res_data;
  logic [FW-1:0]    res_flags;
  logic [SW-1:0]    res_unit;
  logic             res_err;
  logic             busy;

  res_t sb[$];
  res_t exp_r;
  res_t obs_s;
  int   checks = 0;
  int   failures = 0;

  assign obs_s = {res_data, res_flags, res_unit, res_err};

  fpu_result_collector #(
    .DATA_W(DW), .FLAG_W(FW), .NUM_UNITS(NU), .SEL_W(SW),
    .UNIT_MASK(16'h7777), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_sel(issue_sel),
    .unit_data(unit_data), .unit_flags(unit_flags), .unit_ready(unit_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_flags(res_flags), .res_unit(res_unit),
    .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [DW-1:0] d, input logic [FW-1:0] f);
    unit_data[i*DW +: DW]  = d;
    unit_flags[i*FW +: FW] = f;
  endtask

  task automatic issue(input logic [SW-1:0] s, input res_t e);
    issue_valid = 1'b1;
    issue_sel   = s;
    step();
    issue_valid = 1'b0;
    sb.push_back(e);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic pop_exp();
    if (sb.size() == 0) begin
      exp_r = '0;
      failures++;
      $display("FAIL scoreboard_empty got=none required=entry");
    end else begin
      exp_r = sb.pop_front();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if ({issue_ready, busy, res_valid, res_err} !== 4'b1000 || obs_s !== '0) begin
      failures++;
      $display("FAIL reset_values got=%b/%h required=1000/0", {issue_ready, busy, res_valid, res_err}, obs_s);
    end
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    set_slot(1, 32'h0BAD_0BAD, 4'hF);
    issue(4'h1, '{d: 32'h3F80_0000, f: 4'h2, u: 4'h1, e: 1'b0});
    checks++;
    if (issue_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL basic_busy got=%b%b required=01", issue_ready, busy);
    end
    step();
    step();
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early got=%b required=0", res_valid);
    end
    unit_ready[1] = 1'b1;
    set_slot(1, 32'h3F80_0000, 4'h2);
    step();
    unit_ready = '0;
    set_slot(1, 32'hDEAD_BEEF, 4'hF);
    checks++;
    if (res_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency got=%b required=1", res_valid);
    end
    pop_exp();
    checks++;
    if (obs_s !== exp_r) begin
      failures++;
      $display("FAIL basic_result got=%h required=%h", obs_s, exp_r);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (res_valid !== 1'b1 || obs_s !== exp_r) begin
        failures++;
        $display("FAIL basic_hold cyc=%0d got=%b/%h required=1/%h", i, res_valid, obs_s, exp_r);
      end
    end
    accept();
    checks++;
    if ({res_valid, issue_ready, busy} !== 3'b010) begin
      failures++;
      $display("FAIL basic_idle got=%b required=010", {res_valid, issue_ready, busy});
    end
  endtask

  task automatic test_masked();
    set_slot(3, 32'hAAAA_5555, 4'h7);
    issue(4'h3, '{d: '0, f: '0, u: 4'h3, e: 1'b1});
    pop_exp();
    checks++;
    if (res_valid !== 1'b1 || obs_s !== exp_r) begin
      failures++;
      $display("FAIL masked_slot got=%b/%h required=1/%h", res_valid, obs_s, exp_r);
    end
    accept();
    checks++;
    if (issue_ready !== 1'b1) begin
      failures++;
      $display("FAIL masked_idle got=%b required=1", issue_ready);
    end
  endtask

  task automatic test_timeout();
    unit_ready = '0;
    set_slot(9, 32'h4049_0FDB, 4'h1);
    issue(4'h9, '{d: '0, f: '0, u: 4'h9, e: 1'b1});
    step();
    step();
    step();
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_early got=%b required=0", res_valid);
    end
    step();
    pop_exp();
    checks++;
    if (res_valid !== 1'b1 || obs_s !== exp_r) begin
      failures++;
      $display("FAIL timeout_err got=%b/%h required=1/%h", res_valid, obs_s, exp_r);
    end
    accept();
    issue(4'h9, '{d: 32'h4049_0FDB, f: 4'h1, u: 4'h9, e: 1'b0});
    step();
    step();
    step();
    unit_ready[9] = 1'b1;
    step();
    unit_ready = '0;
    pop_exp();
    checks++;
    if (res_valid !== 1'b1 || obs_s !== exp_r) begin
      failures++;
      $display("FAIL timeout_ready_wins got=%b/%h required=1/%h", res_valid, obs_s, exp_r);
    end
    accept();
  endtask

  task automatic test_other_ready();
    set_slot(0, 32'h1111_1111, 4'h1);
    set_slot(5, 32'h5555_5555, 4'h5);
    set_slot(2, 32'h2222_2222, 4'h3);
    issue(4'h2, '{d: 32'h2222_2222, f: 4'h3, u: 4'h2, e: 1'b0});
    unit_ready = 16'h0021;
    step();
    step();
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL other_ready_capture got=%b required=0", res_valid);
    end
    unit_ready = 16'h0004;
    step();
    unit_ready = '0;
    pop_exp();
    checks++;
    if (res_valid !== 1'b1 || obs_s !== exp_r) begin
      failures++;
      $display("FAIL other_ready_result got=%b/%h required=1/%h", res_valid, obs_s, exp_r);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    set_slot(1, 32'hC000_0000, 4'h8);
    set_slot(2, 32'h2222_2222, 4'h3);
    issue(4'h1, '{d: 32'hC000_0000, f: 4'h8, u: 4'h1, e: 1'b0});
    issue_valid = 1'b1;
    issue_sel   = 4'h2;
    unit_ready  = 16'h0004;
    step();
    checks++;
    if (issue_ready !== 1'b0 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_wait_ignore got=%b%b required=00", issue_ready, res_valid);
    end
    unit_ready = 16'h0002;
    step();
    unit_ready = '0;
    issue_sel  = 4'h3;
    pop_exp();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (issue_ready !== 1'b0 || res_valid !== 1'b1 || obs_s !== exp_r) begin
        failures++;
        $display("FAIL b2b_hold_ignore cyc=%0d got=%b%b/%h required=01/%h", i, issue_ready, res_valid, obs_s, exp_r);
      end
      step();
    end
    issue_valid = 1'b0;
    accept();
    step();
    checks++;
    if ({res_valid, busy, issue_ready} !== 3'b001) begin
      failures++;
      $display("FAIL b2b_nothing_queued got=%b required=001", {res_valid, busy, issue_ready});
    end
  endtask

  task automatic test_async_reset();
    set_slot(1, 32'h1234_5678, 4'h5);
    issue(4'h1, '{d: 32'h1234_5678, f: 4'h5, u: 4'h1, e: 1'b0});
    #2 rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    checks++;
    if ({issue_ready, busy, res_valid, res_err} !== 4'b1000 || obs_s !== '0) begin
      failures++;
      $display("FAIL reset_mid_wait got=%b/%h required=1000/0", {issue_ready, busy, res_valid, res_err}, obs_s);
    end
    #2 rst_n = 1'b1;
    step();
    issue(4'h1, '{d: 32'h1234_5678, f: 4'h5, u: 4'h1, e: 1'b0});
    unit_ready[1] = 1'b1;
    step();
    unit_ready = '0;
    pop_exp();
    checks++;
    if (res_valid !== 1'b1 || obs_s !== exp_r) begin
      failures++;
      $display("FAIL reset_min_latency got=%b/%h required=1/%h", res_valid, obs_s, exp_r);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({issue_ready, busy, res_valid, res_err} !== 4'b1000 || obs_s !== '0) begin
      failures++;
      $display("FAIL reset_mid_hold got=%b/%h required=1000/0", {issue_ready, busy, res_valid, res_err}, obs_s);
    end
    #2 rst_n = 1'b1;
    step();
    issue(4'h2, '{d: 32'h2222_2222, f: 4'h3, u: 4'h2, e: 1'b0});
    unit_ready[2] = 1'b1;
    step();
    unit_ready = '0;
    pop_exp();
    checks++;
    if (res_valid !== 1'b1 || obs_s !== exp_r) begin
      failures++;
      $display("FAIL reset_recover got=%b/%h required=1/%h", res_valid, obs_s, exp_r);
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_masked();
    test_timeout();
    test_other_ready();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
